pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction-fetch stage of the MIPS pipeline: holds the program counter, forms the next PC, and owns the IF/ID pipeline register. It sits directly downstream of the 32-bit shift-left-2 stage. It consumes the shifted, sign-extended branch offset to form the branch target, and the jump index to form the jump target. Redirects come from the ID stage, and stall comes from the hazard unit.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset. Must be word-aligned.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hazard-unit hold. When high, the PC and IF/ID registers hold their values.
- `branch_taken` in 1: from ID; the branch resolved as taken.
- `branch_offset_sl2` in 32: from the shift-left-2 stage; byte offset, already ×4.
- `jump` in 1: from ID; J/JAL.
- `jump_index` in 26: from ID; `instr[25:0]`.
- `jump_reg` in 1: from ID; JR/JALR.
- `jr_target` in 32: register value for JR.
- `imem_instr` in 32: asynchronous-read instruction memory data at `pc`.
- `pc` out 32: fetch address to instruction memory.
- `ifid_pc_plus4` out 32: IF/ID register, PC+4 of the held instruction.
- `ifid_instr` out 32: IF/ID register, instruction word.
- `ifid_valid` out 1: IF/ID register holds a real instruction (0 = bubble).
- `misalign_err` out 1: sticky flag; a JR target had nonzero bits [1:0].

## Operation
- Reset values (asynchronous on `rst_n` low):
  - `pc` = `RESET_PC`
  - `ifid_pc_plus4` = 0, `ifid_instr` = `32'h0000_0000` (NOP), `ifid_valid` = 0
  - `misalign_err` = 0
- Redirect request = `jump_reg | jump | branch_taken`. All target arithmetic uses `ifid_pc_plus4`, the instruction currently in ID.
- Next-PC priority, highest first:
  1. `jump_reg`: `{jr_target[31:2], 2'b00}`.
  2. `jump`: `{ifid_pc_plus4[31:28], jump_index, 2'b00}`.
  3. `branch_taken`: `ifid_pc_plus4 + branch_offset_sl2`, 32-bit modulo with carry discarded. Negative offsets wrap naturally, e.g. `0x0000_0004 + 0xFFFF_FFF8` = `0xFFFF_FFFC`.
  4. Otherwise: `pc + 4`, modulo 2^32. `0xFFFF_FFFC` wraps to `0x0000_0000`.
- IF/ID load when not stalled:
  - No redirect: `ifid_pc_plus4` ← `pc+4`, `ifid_instr` ← `imem_instr`, `ifid_valid` ← 1.
  - Redirect: behaviour depends on `BRANCH_DELAY_SLOT_EN` (see Configuration).
- `stall` high: `pc` and the IF/ID registers hold, and redirect inputs are ignored that cycle. ID keeps the redirect asserted until stall drops; the redirect then takes effect.
- Misalignment: any `jump_reg` with `jr_target[1:0] != 0` that is not stalled sets `misalign_err`. The flag clears only on reset. The fetch still proceeds to the aligned address.
- Only the flag is raised; no exception is taken.

## Timing
- Decisions are combinational on the inputs; registers update on the rising edge of `clk`.
- A redirect presented in cycle N makes `pc` equal the target after edge N. The target instruction appears in IF/ID after edge N+1.
- Fetch-to-ID latency is 1 cycle. `imem_instr` must be valid in the same cycle as `pc`.
- `rst_n` asserted mid-cycle clears state immediately. After deassertion, the first edge loads IF/ID from `RESET_PC`.
- If `stall` and a redirect are both asserted in the same cycle, stall wins.

## Configuration
- `BRANCH_DELAY_SLOT_EN` undefined (default): on a redirect, IF/ID loads a bubble. That is `ifid_instr` = 0 and `ifid_valid` = 0, with `ifid_pc_plus4` ← `pc+4`. The slot instruction is squashed, giving a 1-cycle penalty per taken branch or jump.
- `BRANCH_DELAY_SLOT_EN` defined: on a redirect, IF/ID loads the fetched slot instruction normally (`ifid_valid` = 1), per MIPS delay-slot semantics. No bubble is inserted.

## Test plan
- Reset then sequential fetch: `RESET_PC` = 0, no redirects for 4 cycles. Required: `pc` = 0, 4, 8, 0xC; `ifid_pc_plus4` lags `pc` by one cycle at `pc`+4; `ifid_valid` = 1 from the first edge.
- Backward branch: `ifid_pc_plus4` = 0x0000_0010, `branch_offset_sl2` = 0xFFFF_FFF0. Required: next `pc` = 0x0000_0000. With the macro undefined, IF/ID becomes a bubble. With the macro defined, it holds the slot instruction with `ifid_valid` = 1.
- Jump and priority: `jump` = 1, `jump_index` = 0x0000_040, `ifid_pc_plus4` = 0x1000_0008, with `branch_taken` = 1 at the same time. Required: `pc` = 0x1000_0100 (jump wins). Adding `jump_reg` = 1 with `jr_target` = 0x0000_2000 yields `pc` = 0x0000_2000.
- Stall during redirect: `stall` = 1 for 2 cycles with `branch_taken` held. Required: `pc` and IF/ID are unchanged for both cycles; the redirect is applied on the first edge after `stall` drops.
- Misaligned JR: `jr_target` = 0x0000_1006. Required: `pc` = 0x0000_1004 and `misalign_err` = 1, remaining 1 through later normal fetches until `rst_n` pulses low.
- PC wrap and async reset: `pc` = 0xFFFF_FFFC, no redirect. Required: `pc` = 0 next cycle. Asserting `rst_n` low between edges immediately forces `pc` = `RESET_PC`, `ifid_valid` = 0 and `misalign_err` = 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// MIPS instruction-fetch stage: program counter, next-PC selection and the IF/ID register.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the slot instruction on redirects instead of squashing it.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset_sl2,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        misalign_err
);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit SLOT_EN = 1'b1;
`else
  localparam bit SLOT_EN = 1'b0;
`endif

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;

  // Targets are formed from ifid_pc_plus4, the instruction now sitting in ID.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    redirect = jump_reg | jump | branch_taken;
    if (jump_reg)
      next_pc = {jr_target[31:2], 2'b00};
    else if (jump)
      next_pc = {ifid_pc_plus4[31:28], jump_index, 2'b00};
    else if (branch_taken)
      next_pc = ifid_pc_plus4 + branch_offset_sl2;
    else
      next_pc = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (!stall) begin
      pc <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_pc_plus4 <= '0;
      ifid_instr    <= '0;
      ifid_valid    <= 1'b0;
    end else if (!stall) begin
      ifid_pc_plus4 <= pc_plus4;
      if (redirect && !SLOT_EN) begin
        ifid_instr <= '0;
        ifid_valid <= 1'b0;
      end else begin
        ifid_instr <= imem_instr;
        ifid_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if (!stall && jump_reg && (jr_target[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: vector table through a scoreboard queue, then async-reset corner cases.
module tb_pc_fetch_unit;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit SLOT = 1'b1;
`else
  localparam bit SLOT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset_sl2;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jr_target;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        misalign_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_offset_sl2(branch_offset_sl2), .jump(jump), .jump_index(jump_index),
    .jump_reg(jump_reg), .jr_target(jr_target), .imem_instr(imem_instr),
    .pc(pc), .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_instr = imem_fn(pc);

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] off;
    logic        j;
    logic [25:0] jidx;
    logic        jr;
    logic [31:0] jrt;
    logic [31:0] exp_pc;
    logic [31:0] exp_p4;
    logic        exp_v;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] instr;
    logic        v;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [31:0] epc, input logic [31:0] ep4,
                                  input logic ev, input logic eerr);
    exp_t e;
    e.pc = epc; e.p4 = ep4; e.v = ev; e.err = eerr;
    e.instr = ev ? imem_fn(ep4 - 32'd4) : 32'h0;
    return e;
  endfunction

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: queue empty, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " pc"}, pc, e.pc);
      check({tag, " ifid_pc_plus4"}, ifid_pc_plus4, e.p4);
      check({tag, " ifid_instr"}, ifid_instr, e.instr);
      check({tag, " ifid_valid"}, {31'b0, ifid_valid}, {31'b0, e.v});
      check({tag, " misalign_err"}, {31'b0, misalign_err}, {31'b0, e.err});
    end
  endtask

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; branch_offset_sl2 = '0; jump = 0;
    jump_index = '0; jump_reg = 0; jr_target = '0;
  endtask

  task automatic add(input logic s, input logic br, input logic [31:0] off, input logic j,
                     input logic [25:0] jidx, input logic jr, input logic [31:0] jrt,
                     input logic [31:0] epc, input logic [31:0] ep4, input logic ev,
                     input logic eerr);
    vec_t v;
    v.stall = s; v.br = br; v.off = off; v.j = j; v.jidx = jidx; v.jr = jr; v.jrt = jrt;
    v.exp_pc = epc; v.exp_p4 = ep4; v.exp_v = ev; v.exp_err = eerr;
    vecs.push_back(v);
  endtask

  task automatic step(input string tag, input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_pop(tag);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // sequential fetch, backward branch, jump priority, stall, misaligned JR, wrap
    add(0,0,'0,0,'0,0,'0,                       32'h0000_0004, 32'h0000_0004, 1,    0);
    add(0,0,'0,0,'0,0,'0,                       32'h0000_0008, 32'h0000_0008, 1,    0);
    add(0,0,'0,0,'0,0,'0,                       32'h0000_000C, 32'h0000_000C, 1,    0);
    add(0,0,'0,0,'0,0,'0,                       32'h0000_0010, 32'h0000_0010, 1,    0);
    add(0,1,32'hFFFF_FFF0,0,'0,0,'0,            32'h0000_0000, 32'h0000_0014, SLOT, 0);
    add(0,0,'0,0,'0,0,'0,                       32'h0000_0004, 32'h0000_0004, 1,    0);
    add(0,0,'0,0,'0,1,32'h1000_0004,            32'h1000_0004, 32'h0000_0008, SLOT, 0);
    add(0,0,'0,0,'0,0,'0,                       32'h1000_0008, 32'h1000_0008, 1,    0);
    add(0,1,32'h0000_0100,1,26'h40,0,'0,        32'h1000_0100, 32'h1000_000C, SLOT, 0);
    add(0,1,32'h0000_0100,1,26'h40,1,32'h2000,  32'h0000_2000, 32'h1000_0104, SLOT, 0);
    add(0,0,'0,0,'0,0,'0,                       32'h0000_2004, 32'h0000_2004, 1,    0);
    add(1,1,32'h0000_0040,0,'0,0,'0,            32'h0000_2004, 32'h0000_2004, 1,    0);
    add(1,1,32'h0000_0040,0,'0,0,'0,            32'h0000_2004, 32'h0000_2004, 1,    0);
    add(0,1,32'h0000_0040,0,'0,0,'0,            32'h0000_2044, 32'h0000_2008, SLOT, 0);
    add(0,0,'0,0,'0,0,'0,                       32'h0000_2048, 32'h0000_2048, 1,    0);
    add(0,0,'0,0,'0,1,32'h0000_1006,            32'h0000_1004, 32'h0000_204C, SLOT, 1);
    add(0,0,'0,0,'0,0,'0,                       32'h0000_1008, 32'h0000_1008, 1,    1);
    add(0,0,'0,0,'0,1,32'hFFFF_FFFC,            32'hFFFF_FFFC, 32'h0000_100C, SLOT, 1);
    add(0,0,'0,0,'0,0,'0,                       32'h0000_0000, 32'h0000_0000, 1,    1);

    idle_inputs();
    rst_n = 0;
    #12;
    sb.push_back(mk_exp(32'h0, 32'h0, 0, 0));
    compare_pop("reset");
    @(negedge clk);
    rst_n = 1;

    foreach (vecs[i]) begin
      stall = vecs[i].stall; branch_taken = vecs[i].br; branch_offset_sl2 = vecs[i].off;
      jump = vecs[i].j; jump_index = vecs[i].jidx; jump_reg = vecs[i].jr; jr_target = vecs[i].jrt;
      step($sformatf("vec%0d", i),
           mk_exp(vecs[i].exp_pc, vecs[i].exp_p4, vecs[i].exp_v, vecs[i].exp_err));
    end

    // reset asserted between edges must clear state without waiting for a clock
    idle_inputs();
    @(negedge clk);
    rst_n = 0;
    #1;
    sb.push_back(mk_exp(32'h0, 32'h0, 0, 0));
    compare_pop("async_reset");
    @(negedge clk);
    rst_n = 1;
    step("post_reset", mk_exp(32'h4, 32'h4, 1, 0));

    // stalled misaligned JR must neither move the PC nor set the flag
    stall = 1; jump_reg = 1; jr_target = 32'h0000_3003;
    step("stalled_jr", mk_exp(32'h4, 32'h4, 1, 0));

    // negative branch offset wrapping below zero: 0x4 + 0xFFFF_FFF8
    idle_inputs();
    branch_taken = 1; branch_offset_sl2 = 32'hFFFF_FFF8;
    step("neg_wrap", mk_exp(32'hFFFF_FFFC, 32'h8, SLOT, 0));
    idle_inputs();
    step("pc_wrap", mk_exp(32'h0, 32'h0, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
